// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    FIXUP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_U,
    MODE_S,
    MODE_SU
  } mode_t;

  // Width of the iteration counter for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit and try to subtract.
module div_step #(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE:0]   rem,
  input  logic            dvd_msb,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE:0]   next_rem,
  output logic            q_bit
);

  localparam int unsigned RW = SIZE + 1;

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;

  // The top remainder bit is always clear (rem < divisor), so it drops out of the shift.
  assign shifted = RW'({rem, dvd_msb});

  // Carry-out of shifted + ~divisor + 1 is the "no borrow" flag.
  sklansky_adder #(.WIDTH(RW)) u_sub (
    .a    (shifted),
    .b    (~{1'b0, divisor}),
    .cin  (1'b1),
    .sum  (trial),
    .cout (q_bit)
  );

  assign next_rem = q_bit ? trial : shifted;

endmodule

// File: rtl/sklansky_adder.sv
// Parallel-prefix (Sklansky) adder with carry-in and carry-out.
module sklansky_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gv;
  logic [WIDTH-1:0] pv;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] pn;

  // Prefix tree: group generate of bits [i:0], carry-in folded into bit 0.
  always_comb begin
    int j;
    j    = 0;
    prop = a ^ b;
    gv   = a & b;
    gv[0] = gv[0] | (prop[0] & cin);
    pv   = prop;
    gn   = gv;
    pn   = pv;
    for (int l = 0; l < int'(LEVELS); l++) begin
      gn = gv;
      pn = pv;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
          gn[i] = gv[i] | (pv[i] & gv[j]);
          pn[i] = pv[i] & pv[j];
        end
      end
      gv = gn;
      pv = pn;
    end
    sum  = prop ^ {gv[WIDTH-2:0], cin};
    cout = gv[WIDTH-1];
  end

endmodule

// File: rtl/divider_msu.sv
// Iterative radix-2 restoring divider with unsigned/signed/mixed operand modes.
module divider_msu
  import divider_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            sign,
  input  logic            mix,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] r,
  output logic            div_by_zero
);

  localparam int unsigned CW = cnt_width(SIZE);
  localparam int unsigned RW = SIZE + 1;

  state_t          state;
  state_t          state_next;
  mode_t           mode;
  logic [SIZE-1:0] a_reg;
  logic [SIZE-1:0] b_reg;
  logic [SIZE-1:0] dvd;
  logic [SIZE-1:0] dvs;
  logic [RW-1:0]   rem;
  logic [RW-1:0]   next_rem;
  logic            q_bit;
  logic [CW-1:0]   cnt;
  logic            q_neg;
  logic            r_neg;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic            in_ready_next;
  logic            out_valid_next;

  assign accept = in_valid & in_ready;
  assign a_neg  = (mode != MODE_U) & a_reg[SIZE-1];
  assign b_neg  = (mode == MODE_S) & b_reg[SIZE-1];

  div_step #(.SIZE(SIZE)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[SIZE-1]),
    .divisor  (dvs),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PREP;
      PREP:    state_next = (b_reg == '0) ? DONE : DIV;
      DIV:     if (cnt == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs, registered from the upcoming state.
  always_comb begin
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == DONE);
  end

  // Datapath: operand latch, magnitude prep, shift/subtract, sign fixup.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      mode        <= MODE_U;
      a_reg       <= '0;
      b_reg       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            mode  <= sign ? MODE_S : (mix ? MODE_SU : MODE_U);
          end
        end
        PREP: begin
          dvd         <= a_neg ? -a_reg : a_reg;
          dvs         <= b_neg ? -b_reg : b_reg;
          q_neg       <= a_neg ^ b_neg;
          r_neg       <= a_neg;
          rem         <= '0;
          cnt         <= CW'(SIZE - 1);
          div_by_zero <= (b_reg == '0);
          if (b_reg == '0) begin
            q <= '1;
            r <= a_reg;
          end
        end
        DIV: begin
          rem <= next_rem;
          dvd <= {dvd[SIZE-2:0], q_bit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          q <= q_neg ? -dvd : dvd;
          r <= r_neg ? -rem[SIZE-1:0] : rem[SIZE-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider_msu.md
Name: divider_msu

Overview:
Iterative radix-2 restoring divider, the inverse of the signed/unsigned/mixed carry-save multiplier. It supports the same three operand modes (unsigned, signed, mixed) and produces quotient and remainder. It sits beside the multiplier in the arithmetic unit, with a valid/ready handshake on both sides. It computes one quotient bit per cycle and reuses sklansky_adder as its subtractor.

Parameters:
SIZE, 32, operand width in bits (>= 4, power of two)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode are valid
in_ready  output  1  block can accept an operation
a  input  SIZE  dividend
b  input  SIZE  divisor
sign  input  1  both operands are two's complement
mix  input  1  a is signed and b is unsigned; ignored when sign=1
out_valid  output  1  results are valid
out_ready  input  1  consumer accepts the results
q  output  SIZE  quotient
r  output  SIZE  remainder
div_by_zero  output  1  b was zero for this result

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0, counter=0.
- Reset mid-operation: the operation is aborted and discarded. The cycle after reset deasserts shows in_ready=1 and out_valid=0.
- Modes:
  - sign=1: a signed, b signed.
  - sign=0, mix=1: a signed, b unsigned.
  - sign=0, mix=0: both unsigned.
  - Mode is latched at acceptance.
- Semantics: truncating division.
  - Quotient sign = sign(a) XOR sign(b). An unsigned b is never negative.
  - Remainder sign = sign(a).
  - |r| < |b|.
- Overflow: signed 0x80..0 / -1 gives q=0x80..0, r=0. No flag is raised. This falls out of the magnitude datapath because |a|=2^(SIZE-1) fits in SIZE bits unsigned.
- Divide by zero: q=all ones, r=a unmodified, div_by_zero=1, in every mode.
- Handshake:
  - Accept occurs on a clk edge with in_valid and in_ready both high.
  - in_ready is high only in IDLE.
  - out_valid and results stay stable until the edge where out_valid and out_ready are both high.
  - There is no accept in the same cycle as output retire. in_ready rises the cycle after retire.
- State machine:
  - IDLE: on accept, latch a, b and mode; go to PREP.
  - PREP (1 cycle): take magnitudes of signed operands; record result signs; clear the partial remainder; counter=SIZE-1. If b==0, load the div-by-zero results and go to DONE; otherwise go to DIV.
  - DIV (SIZE cycles): shift {rem, dvd} left by 1, then trial = rem - |b| via sklansky_adder with the b side inverted and cin=1. If there is no borrow, rem=trial and the new quotient bit is 1; otherwise the quotient bit is 0 and rem is kept. When counter==0, go to FIXUP; otherwise decrement the counter.
  - FIXUP (1 cycle): negate the quotient and/or remainder per the recorded signs, register q and r, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency, counted from the accept edge to out_valid high:
  - SIZE+2 cycles normally.
  - 1 cycle for divide by zero.
- Widths:
  - Partial remainder is SIZE+1 bits, so the borrow is observable with an unsigned divisor up to 2^SIZE-1.
  - Counter is $clog2(SIZE) bits.
- Inputs are don't-care outside the accept edge. sign and mix changing mid-operation have no effect.

Decomposition:
- divider_pkg holds:
  - state_t enum {IDLE, PREP, DIV, FIXUP, DONE}
  - mode_t enum {MODE_U, MODE_S, MODE_SU}
  - constant function for the counter width
- Sub-module div_step: one combinational restoring step.
  - Inputs: rem, dvd_msb, divisor.
  - Outputs: next_rem, q_bit.
  - Wraps sklansky_adder #(SIZE+1).

Test Plan:
- Unsigned, a=100, b=7 -> q=14, r=2, div_by_zero=0; out_valid exactly 34 cycles after accept (SIZE=32).
- Signed, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Signed, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
- Mixed, a=0xFFFFFFF8 (-8), b=3 -> q=0xFFFFFFFE, r=0xFFFFFFFE. Mixed, a=0xFFFFFFF9, b=0xFFFFFFFF -> q=0, r=0xFFFFFFF9.
- Divide by zero, a=0x12345678, b=0, any mode -> q=0xFFFFFFFF, r=0x12345678, div_by_zero=1; out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> q, r and out_valid stable and in_ready=0 throughout; after retire, in_ready=1 the next cycle; a back-to-back second operation gives correct results.
- Reset at DIV iteration 10 -> next cycle out_valid=0, in_ready=1, q=r=0; a following 100/7 gives q=14, r=2.
